// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus between the LSU sequencer (master) and data memory (slave).
// Valid/grant request phase followed by a read-data-valid response phase.
interface lsu_mem_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// LSU memory controller: sequences one load/store at a time onto the data bus,
// stalling the core until the access completes, is rejected as misaligned,
// or times out. Handles byte-lane steering for stores and extension for loads.
module lsu_mem_ctrl #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          stall,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          misalign,
    output logic          bus_err,
    lsu_mem_ctrl_if.master mem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state_reg, state_next;
    logic [7:0]    cnt_reg;
    logic [AW-1:0] addr_reg;
    logic [1:0]    size_reg;
    logic          we_reg;
    logic          uns_reg;
    logic [3:0]    be_reg;
    logic [DW-1:0] wdata_reg;
    logic [DW-1:0] rdata_reg;
    logic          mis_reg;
    logic          err_reg;

    logic          misaligned;
    logic [3:0]    be_new;
    logic [DW-1:0] wdata_new;
    logic [DW-1:0] shifted;
    logic [DW-1:0] ext_rdata;
    logic          timeout_hit;
    logic          load_done;
    logic          err_hit;

    // Size 11 is treated like a misaligned access: rejected without touching the bus.
    assign misaligned = (req_size == 2'b11)
                      | ((req_size == 2'b01) & req_addr[0])
                      | ((req_size == 2'b10) & (|req_addr[1:0]));

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = req_wdata;
        case (req_size)
            2'b00: begin
                be_new    = 4'b0001 << req_addr[1:0];
                wdata_new = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << req_addr[1:0];
                wdata_new = {2{req_wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = req_wdata;
            end
        endcase
    end

    assign shifted = mem.mem_rdata >> {addr_reg[1:0], 3'b000};

    // Right-justify the addressed lane(s) and sign/zero-extend per latched size.
    always_comb begin
        ext_rdata = shifted;
        case (size_reg)
            2'b00:   ext_rdata = {{24{~uns_reg & shifted[7]}}, shifted[7:0]};
            2'b01:   ext_rdata = {{16{~uns_reg & shifted[15]}}, shifted[15:0]};
            default: ext_rdata = shifted;
        endcase
    end

    // Completion has priority over a timeout landing in the same cycle.
    assign timeout_hit = (cnt_reg == 8'(TIMEOUT - 1));
    assign load_done   = ((state_reg == REQ) & mem.mem_gnt & ~we_reg & mem.mem_rvalid)
                       | ((state_reg == WAIT) & mem.mem_rvalid);
    assign err_hit     = timeout_hit & (((state_reg == REQ) & ~mem.mem_gnt)
                                      | ((state_reg == WAIT) & ~mem.mem_rvalid));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) state_next = misaligned ? RESP : REQ;
            end
            REQ: begin
                if (mem.mem_gnt) state_next = (we_reg | mem.mem_rvalid) ? RESP : WAIT;
                else if (timeout_hit) state_next = RESP;
            end
            WAIT: begin
                if (mem.mem_rvalid || timeout_hit) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, timeout counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            addr_reg  <= '0;
            size_reg  <= '0;
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            be_reg    <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            mis_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        cnt_reg   <= '0;
                        rdata_reg <= '0;
                        err_reg   <= 1'b0;
                        mis_reg   <= misaligned;
                        if (!misaligned) begin
                            addr_reg  <= req_addr;
                            size_reg  <= req_size;
                            we_reg    <= req_we;
                            uns_reg   <= req_unsigned;
                            be_reg    <= be_new;
                            wdata_reg <= wdata_new;
                        end
                    end
                end
                REQ, WAIT: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    if (load_done)    rdata_reg <= ext_rdata;
                    else if (err_hit) err_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign stall     = req_valid & (state_reg != RESP);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rsp_valid ? rdata_reg : '0;
    assign misalign  = rsp_valid & mis_reg;
    assign bus_err   = rsp_valid & err_reg;

    assign mem.mem_req   = (state_reg == REQ);
    assign mem.mem_we    = we_reg;
    assign mem.mem_addr  = {addr_reg[AW-1:2], 2'b00};
    assign mem.mem_be    = be_reg;
    assign mem.mem_wdata = wdata_reg;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: bus responder driven per access, responses
// checked against a scoreboard queue filled when each request is issued.
module tb_lsu_mem_ctrl;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misalign;
    logic        bus_err;

    lsu_mem_ctrl_if #(.AW(32), .DW(32)) mem_if ();

    lsu_mem_ctrl #(.DW(32), .AW(32), .TIMEOUT(255)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .misalign     (misalign),
        .bus_err      (bus_err),
        .mem          (mem_if)
    );

    localparam int TMO = 255;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_rsp", sb_q.size(), 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                check_eq({e.tag, "_mis"}, misalign, e.mis);
                check_eq({e.tag, "_err"}, bus_err, e.err);
                $display("txn %s rdata=%h misalign=%b bus_err=%b", e.tag, rsp_rdata, misalign, bus_err);
            end
        end
    end

    // One access: gnt_wait = REQ cycles without grant before granting (-1 never),
    // rv_wait = cycles from grant to rvalid (0 = same cycle).
    task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rword, input int gnt_wait, input int rv_wait,
                             input logic [31:0] exp_rdata, input logic exp_mis, input logic exp_err,
                             input int exp_lat, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        int cyc;
        int req_cyc;
        int gnt_cyc;
        int exp_req;
        bit done;
        sb_q.push_back('{tag, exp_rdata, exp_mis, exp_err});
        @(posedge clk); #1;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        cyc = 1; req_cyc = 0; gnt_cyc = -1; done = 1'b0;
        while (!done && cyc <= 400) begin
            @(negedge clk);
            if (cyc == 1) check_eq({tag, "_stall"}, stall, 1'b1);
            if (rsp_valid) begin
                check_eq({tag, "_lat"}, cyc, exp_lat);
                check_eq({tag, "_stall_rsp"}, stall, 1'b0);
                done = 1'b1;
            end else if (mem_if.mem_req) begin
                if (req_cyc == 0) begin
                    check_eq({tag, "_be"}, mem_if.mem_be, exp_be);
                    check_eq({tag, "_wdata"}, mem_if.mem_wdata, exp_wdata);
                    check_eq({tag, "_addr"}, mem_if.mem_addr, {addr[31:2], 2'b00});
                    check_eq({tag, "_we"}, mem_if.mem_we, we);
                end
                if (gnt_wait >= 0 && req_cyc == gnt_wait) begin
                    mem_if.mem_gnt = 1'b1;
                    gnt_cyc = cyc;
                    if (!we && rv_wait == 0) begin
                        mem_if.mem_rvalid = 1'b1;
                        mem_if.mem_rdata  = rword;
                    end
                end
                req_cyc++;
            end else if (gnt_cyc >= 0 && !we && (cyc - gnt_cyc) == rv_wait) begin
                mem_if.mem_rvalid = 1'b1;
                mem_if.mem_rdata  = rword;
            end
            @(posedge clk); #1;
            mem_if.mem_gnt    = 1'b0;
            mem_if.mem_rvalid = 1'b0;
            mem_if.mem_rdata  = $urandom;
            if (done) req_valid = 1'b0;
            cyc++;
        end
        check_eq({tag, "_done"}, done, 1'b1);
        if (done) begin
            exp_req = exp_mis ? 0 : ((gnt_wait < 0) ? TMO : gnt_wait + 1);
            check_eq({tag, "_reqcyc"}, req_cyc, exp_req);
        end else begin
            req_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        // Reset state: everything low except stall, which follows req_valid.
        check_eq("rst_stall_hi", stall, 1'b1);
        check_eq("rst_mem_req", mem_if.mem_req, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_misalign", misalign, 1'b0);
        check_eq("rst_bus_err", bus_err, 1'b0);
        check_eq("rst_mem_be", mem_if.mem_be, 4'h0);
        req_valid = 1'b0;
        #1 check_eq("rst_stall_lo", stall, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        //         tag     we sz uns addr          wdata         rword         g  r  exp_rdata     mis err lat be       exp_wdata
        do_access("SB",    1, 0, 0, 32'h0000_1003, 32'h0000_00A5, 32'h0,       0, 0, 32'h0,        0, 0, 3, 4'b1000, 32'hA5A5_A5A5);
        do_access("LB",    0, 0, 0, 32'h0000_2001, 32'h0,        32'h0000_8000, 0, 1, 32'hFFFF_FF80, 0, 0, 4, 4'b0010, 32'h0);
        do_access("LBU",   0, 0, 1, 32'h0000_2001, 32'h0,        32'h0000_8000, 0, 1, 32'h0000_0080, 0, 0, 4, 4'b0010, 32'h0);
        do_access("LH",    0, 1, 0, 32'h0000_2002, 32'h0,        32'h8001_0000, 0, 0, 32'hFFFF_8001, 0, 0, 3, 4'b1100, 32'h0);
        do_access("LWmis", 0, 2, 0, 32'h0000_3002, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 2, 4'b0000, 32'h0);
        do_access("SZ11",  0, 3, 0, 32'h0000_3000, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 2, 4'b0000, 32'h0);
        do_access("LHmis", 0, 1, 0, 32'h0000_3001, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 2, 4'b0000, 32'h0);
        do_access("SH",    1, 1, 0, 32'h0000_1002, 32'h0000_1234, 32'h0,       0, 0, 32'h0,        0, 0, 3, 4'b1100, 32'h1234_1234);
        do_access("SWg2",  1, 2, 0, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,       2, 0, 32'h0,        0, 0, 5, 4'b1111, 32'hCAFE_F00D);
        do_access("LWd",   0, 2, 0, 32'h0000_4004, 32'h0,        32'hDEAD_BEEF, 1, 2, 32'hDEAD_BEEF, 0, 0, 6, 4'b1111, 32'h0);
        do_access("LHU",   0, 1, 1, 32'h0000_4002, 32'h0,        32'hDEAD_BEEF, 0, 1, 32'h0000_DEAD, 0, 0, 4, 4'b1100, 32'h0);
        do_access("LHs",   0, 1, 0, 32'h0000_4002, 32'h0,        32'hDEAD_BEEF, 0, 1, 32'hFFFF_DEAD, 0, 0, 4, 4'b1100, 32'h0);
        do_access("LB3",   0, 0, 0, 32'h0000_4003, 32'h0,        32'h7F00_0000, 0, 1, 32'h0000_007F, 0, 0, 4, 4'b1000, 32'h0);
        do_access("LB0",   0, 0, 0, 32'h0000_4000, 32'h0,        32'h0000_00F0, 0, 0, 32'hFFFF_FFF0, 0, 0, 3, 4'b0001, 32'h0);
        do_access("SWto",  1, 2, 0, 32'h0000_6000, 32'h1122_3344, 32'h0,      -1, 0, 32'h0,        0, 1, 257, 4'b1111, 32'h1122_3344);

        // A late grant/rvalid in IDLE must not produce a response or a request.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_if.mem_gnt = 1'b1; mem_if.mem_rvalid = 1'b1;
            check_eq("late_gnt_req", mem_if.mem_req, 1'b0);
            check_eq("late_gnt_rsp", rsp_valid, 1'b0);
        end
        @(negedge clk);
        mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0;
        check_eq("late_gnt_rsp_end", rsp_valid, 1'b0);

        // Reset while waiting for read data abandons the access.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_5000;
        @(negedge clk);
        @(negedge clk);
        check_eq("rstw_req", mem_if.mem_req, 1'b1);
        mem_if.mem_gnt = 1'b1;
        @(posedge clk); #1 mem_if.mem_gnt = 1'b0;
        @(negedge clk);
        check_eq("rstw_wait_req", mem_if.mem_req, 1'b0);
        check_eq("rstw_wait_stall", stall, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rstw_req_async", mem_if.mem_req, 1'b0);
        check_eq("rstw_rsp", rsp_valid, 1'b0);
        req_valid = 1'b0;
        mem_if.mem_rvalid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("rstw_rsp_hold", rsp_valid, 1'b0);
        end
        mem_if.mem_rvalid = 1'b0;
        rst_n = 1'b1;
        do_access("LWpost", 0, 2, 0, 32'h0000_5000, 32'h0, 32'h0123_4567, 0, 1, 32'h0123_4567, 0, 0, 4, 4'b1111, 32'h0);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
